serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Parallel-in, serial-out frame transmitter. It produces the single-bit `d` stream that the team's flip-flop capture path samples.
- Takes a DATA_W word over a valid/ready handshake.
- Emits one frame per word: start bit, data bits, stop bit, each held for CLKS_PER_BIT clocks.
- Drives a true and a complementary line output, matching the q/qb convention of the capture flop.

Parameters:
- DATA_W, 8: data bits per frame; must be >= 1.
- CLKS_PER_BIT, 4: clocks each bit is held on the line; must be >= 1.
- LSB_FIRST, 1: 1 = bit 0 is sent first; 0 = bit DATA_W-1 is sent first.

Ports:
- clk  input  1: single clock; all state changes on the rising edge.
- reset  input  1: asynchronous, active-low reset (0 = in reset). This is the name and polarity for this block.
- tx_data  input  DATA_W: word to send; sampled only at acceptance.
- tx_valid  input  1: producer has a word.
- tx_ready  output  1: block can accept a word; high only in IDLE.
- ser_out  output  1: serial line; idle level is 1.
- ser_out_b  output  1: always the inverse of ser_out (registered together with it, never skewed).
- busy  output  1: frame in progress (state is not IDLE).
- done  output  1: one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, ser_out=1, ser_out_b=0, tx_ready=1, busy=0, done=0; shift register and counters cleared.
- All outputs are registered.
- Acceptance: tx_valid && tx_ready at a rising edge E0. At that edge:
  - tx_data is captured into the shift register.
  - state becomes START, ser_out becomes 0, tx_ready becomes 0, busy becomes 1.
- tx_data and tx_valid are ignored while not in IDLE; tx_data changes after acceptance have no effect.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each non-IDLE state lasts CLKS_PER_BIT clocks per bit, timed by the bit timer.
  - START drives 0.
  - DATA drives DATA_W bits in order set by LSB_FIRST, shifting on each bit-timer wrap; the bit index counts 0..DATA_W-1.
  - STOP drives 1.
- Frame timing: the line is low from E0 for CLKS_PER_BIT cycles. Data bit k occupies cycles E0+(k+1)*CLKS_PER_BIT through E0+(k+2)*CLKS_PER_BIT-1.
- Return to IDLE: at E0+(DATA_W+2)*CLKS_PER_BIT the block returns to IDLE, with ser_out=1, tx_ready=1, busy=0 and done=1 for exactly that one cycle.
- Back-to-back frames: a word may be accepted in the first IDLE cycle (the cycle done is high). This gives a minimum of one idle-level cycle between frames beyond the stop bit.
- CLKS_PER_BIT=1: one clock per bit; the timer is degenerate (wraps every cycle).
- Reset asserted mid-frame: immediate return to reset values. The frame is discarded, no done pulse is produced, and the line goes high asynchronously.
- Invariant: ser_out_b == ~ser_out in every cycle, including reset.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of the captured word) for CLKS_PER_BIT clocks. Frame length becomes (DATA_W+3)*CLKS_PER_BIT; done and the return to IDLE move later by CLKS_PER_BIT.
- Undefined: no parity state, no parity logic; frame length is (DATA_W+2)*CLKS_PER_BIT.

Decomposition:
- Package serial_pkg holds:
  - typedef for the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE=1'b1, LINE_START=1'b0, LINE_STOP=1'b1.
  - PARITY stays in the enum even when the feature is off, so that encodings are stable.
- One sub-module, bit_timer:
  - parameter CLKS_PER_BIT;
  - inputs clk, reset (same polarity), clear, enable;
  - output tick, a one-cycle pulse every CLKS_PER_BIT enabled cycles.
  - serial_tx uses it for all bit timing.

Test Plan:
- Reset hold: reset=0 for 3 cycles with tx_valid=1 -> ser_out=1, ser_out_b=0, tx_ready=1, busy=0, done=0, no frame starts.
- Single frame: send 0xA5 (DATA_W=8, CLKS_PER_BIT=4, LSB_FIRST=1) -> start 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop 1 for 4 cycles. done pulses at E0+40. ser_out_b is the inverse throughout.
- Back-to-back: 0x00 then 0xFF with tx_valid held high -> second accept occurs on the done cycle; the line shows exactly one extra high cycle between frames; tx_ready is low for 40 cycles per frame.
- Ignored input: change tx_data to 0x3C and pulse tx_valid mid-frame -> the transmitted bits remain 0xA5, and no second frame is queued.
- Reset mid-frame: assert reset during data bit 3 -> ser_out=1 immediately (asynchronous), no done pulse; after release the next accepted word transmits cleanly.
- Parity (SERIAL_TX_PARITY_EN): send 0x07 -> parity bit 1 appears before the stop bit, and done pulses at E0+44.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// The state encoding includes PARITY even when SERIAL_TX_PARITY_EN is undefined.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: tick pulses on every CLKS_PER_BIT-th enabled cycle.
// With CLKS_PER_BIT=1 the counter never moves and tick simply follows enable.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start, DATA_W data bits, stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              ser_out_b,
  output logic              busy,
  output logic              done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic [IW-1:0]     bit_idx;
  logic              tick;
  logic              accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_bit;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  assign accept  = tx_valid && tx_ready;
  assign sh_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(busy),
    .tick  (tick)
  );

  // ser_out_b is written alongside ser_out everywhere so the pair can never skew.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      ser_out    <= LINE_IDLE;
      ser_out_b  <= ~LINE_IDLE;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= tx_data;
            bit_idx    <= '0;
            state      <= START;
            ser_out    <= LINE_START;
            ser_out_b  <= ~LINE_START;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state     <= DATA;
            bit_idx   <= '0;
            ser_out   <= first_bit(shreg);
            ser_out_b <= ~first_bit(shreg);
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
              state     <= PARITY;
              ser_out   <= parity_bit;
              ser_out_b <= ~parity_bit;
`else
              state     <= STOP;
              ser_out   <= LINE_STOP;
              ser_out_b <= ~LINE_STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shreg     <= sh_next;
              ser_out   <= first_bit(sh_next);
              ser_out_b <= ~first_bit(sh_next);
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state     <= STOP;
            ser_out   <= LINE_STOP;
            ser_out_b <= ~LINE_STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state     <= IDLE;
            ser_out   <= LINE_IDLE;
            ser_out_b <= ~LINE_IDLE;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ser_out   <= LINE_IDLE;
          ser_out_b <= ~LINE_IDLE;
          tx_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: frames compared cycle by cycle against a slot-based line model.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
module tb_serial_tx;

  localparam int W    = 8;
  localparam int CPB  = 4;
  localparam bit LSBF = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = (W + 3) * CPB;
`else
  localparam int FL = (W + 2) * CPB;
`endif

  logic         clk      = 1'b0;
  logic         reset    = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         ser_out;
  logic         ser_out_b;
  logic         busy;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  // {ser_out, ser_out_b, tx_ready, busy, done}
  localparam logic [4:0] IDLE_VEC = 5'b10100;
  localparam logic [4:0] DONE_VEC = 5'b10101;

  serial_tx #(
    .DATA_W      (W),
    .CLKS_PER_BIT(CPB),
    .LSB_FIRST   (LSBF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ser_out  (ser_out),
    .ser_out_b(ser_out_b),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level t cycles after the accepting edge, from the frame layout alone.
  function automatic logic model_line(input logic [W-1:0] w, input int t);
    int slot;
    slot = t / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= W) return LSBF ? w[slot-1] : w[W-slot];
`ifdef SERIAL_TX_PARITY_EN
    if (slot == W + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Accepts w at the next edge and checks every cycle through the done cycle.
  // Returns positioned on the done cycle; keep_valid leaves tx_valid high for chaining.
  task automatic run_frame(input logic [W-1:0] w, input bit keep_valid, input bit disturb,
                           input string tag);
    logic       l;
    logic [4:0] exp_v;
    logic [4:0] got;
    tx_data  = w;
    tx_valid = 1'b1;
    step();
    if (!keep_valid) tx_valid = 1'b0;
    for (int t = 0; t <= FL; t++) begin
      l     = model_line(w, t);
      exp_v = (t == FL) ? DONE_VEC : {l, ~l, 1'b0, 1'b1, 1'b0};
      got   = {ser_out, ser_out_b, tx_ready, busy, done};
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL %s word=%h t=%0d got=%b expected=%b", tag, w, t, got, exp_v);
      end
      if (disturb && t == 3 * CPB) begin
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
      end
      if (disturb && t == 3 * CPB + 1) tx_valid = 1'b0;
      if (t < FL) step();
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = W'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      got = {ser_out, ser_out_b, tx_ready, busy, done};
      vectors++;
      if (got !== IDLE_VEC) begin
        miscompares++;
        $display("FAIL reset_hold cycle=%0d got=%b expected=%b", i, got, IDLE_VEC);
      end
    end
    tx_valid = 1'b0;
    reset    = 1'b1;
    step();
    got = {ser_out, ser_out_b, tx_ready, busy, done};
    vectors++;
    if (got !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL reset_release got=%b expected=%b", got, IDLE_VEC);
    end
  endtask

  task automatic test_single();
    logic [4:0] got;
    run_frame(8'hA5, 1'b0, 1'b0, "single_a5");
    step();
    got = {ser_out, ser_out_b, tx_ready, busy, done};
    vectors++;
    if (got !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL single_after got=%b expected=%b", got, IDLE_VEC);
    end
  endtask

  task automatic test_random();
    logic [4:0]   got;
    logic [W-1:0] w;
    int           gap;
    for (int n = 0; n < 6; n++) begin
      w   = W'($urandom);
      gap = int'($urandom_range(1, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        got = {ser_out, ser_out_b, tx_ready, busy, done};
        vectors++;
        if (got !== IDLE_VEC) begin
          miscompares++;
          $display("FAIL random_gap n=%0d got=%b expected=%b", n, got, IDLE_VEC);
        end
      end
      run_frame(w, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got;
    step();
    run_frame(8'h00, 1'b1, 1'b0, "b2b_first");
    run_frame(8'hFF, 1'b0, 1'b0, "b2b_second");
    step();
    got = {ser_out, ser_out_b, tx_ready, busy, done};
    vectors++;
    if (got !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL b2b_after got=%b expected=%b", got, IDLE_VEC);
    end
  endtask

  task automatic test_ignored_input();
    logic [4:0] got;
    step();
    run_frame(8'hA5, 1'b0, 1'b1, "ignored_input");
    for (int i = 0; i < 2; i++) begin
      step();
      got = {ser_out, ser_out_b, tx_ready, busy, done};
      vectors++;
      if (got !== IDLE_VEC) begin
        miscompares++;
        $display("FAIL ignored_no_queue cycle=%0d got=%b expected=%b", i, got, IDLE_VEC);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    logic [4:0]   got;
    logic [4:0]   exp_v;
    logic         l;
    step();
    w        = W'($urandom) & ~W'(8'h08);
    tx_data  = w;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 4 * CPB + 1; i++) step();
    l     = model_line(w, 4 * CPB + 1);
    exp_v = {l, ~l, 1'b0, 1'b1, 1'b0};
    got   = {ser_out, ser_out_b, tx_ready, busy, done};
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL mid_before_reset got=%b expected=%b", got, exp_v);
    end
    #2;
    reset = 1'b0;
    #1;
    got = {ser_out, ser_out_b, tx_ready, busy, done};
    vectors++;
    if (got !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL mid_async_reset got=%b expected=%b", got, IDLE_VEC);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      got = {ser_out, ser_out_b, tx_ready, busy, done};
      vectors++;
      if (got !== IDLE_VEC) begin
        miscompares++;
        $display("FAIL mid_reset_hold cycle=%0d got=%b expected=%b", i, got, IDLE_VEC);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < FL + 2; i++) begin
      step();
      got = {ser_out, ser_out_b, tx_ready, busy, done};
      vectors++;
      if (got !== IDLE_VEC) begin
        miscompares++;
        $display("FAIL mid_no_done cycle=%0d got=%b expected=%b", i, got, IDLE_VEC);
      end
    end
    run_frame(W'($urandom), 1'b0, 1'b0, "after_mid_reset");
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    step();
    run_frame(8'h07, 1'b0, 1'b0, "parity_07");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_frame();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
